// File: rtl/rv32i_types.sv
// Shared type definitions for the memory-side blocks of the core.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/arbiter_control.sv
// Arbitration FSM: data-priority grant with a one-shot instruction grant after
// each data transaction so a streaming D-cache cannot starve the I-cache.
module arbiter_control
    import rv32i_types::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_read,
    input  logic       d_read,
    input  logic       d_write,
    input  logic       pmem_resp,
    output arb_state_t state,
    output logic       grant_i,
    output logic       grant_d
);

    grant_t last_grant;
    logic   d_req;

    // Grants are only decoded in IDLE; they load the datapath latches on the same edge.
    always_comb begin
        d_req   = d_read | d_write;
        grant_d = (state == IDLE) && d_req && !(i_read && (last_grant == GRANT_D));
        grant_i = (state == IDLE) && i_read && !grant_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state      <= D_BUSY;
                        last_grant <= GRANT_D;
                    end else if (grant_i) begin
                        state      <= I_BUSY;
                        last_grant <= GRANT_I;
                    end
                end
                I_BUSY, D_BUSY: begin
                    if (pmem_resp) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache line reads and D-cache reads/write-backs onto a single
// physical memory port; the granted request is latched and held for the whole transaction.
module mem_arbiter
    import rv32i_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);

    arb_state_t        state;
    logic              grant_i, grant_d;
    logic              rd_q, wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;

    arbiter_control u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_read    (i_read),
        .d_read    (d_read),
        .d_write   (d_write),
        .pmem_resp (pmem_resp),
        .state     (state),
        .grant_i   (grant_i),
        .grant_d   (grant_d)
    );

    // A simultaneous d_read/d_write is treated as a write-back only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant_d) begin
            addr_q  <= d_address;
            wdata_q <= d_wdata;
            wr_q    <= d_write;
            rd_q    <= ~d_write;
        end else if (grant_i) begin
            addr_q  <= i_address;
            rd_q    <= 1'b1;
            wr_q    <= 1'b0;
        end else if ((state != IDLE) && pmem_resp) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end
    end

    assign pmem_read    = rd_q;
    assign pmem_write   = wr_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    // Responses are gated by state so a stray pmem_resp in IDLE never reaches a cache.
    assign i_resp  = (state == I_BUSY) && pmem_resp;
    assign d_resp  = (state == D_BUSY) && pmem_resp;
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

endmodule
